// File: rtl/core_pkg.sv
// core_pkg: shared widths, NOP encoding, if_id entry layout and fill-state encodings
package core_pkg;
  localparam int XLEN = 32;
  localparam int DEPTH = 2;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_four;
    logic [XLEN-1:0] instr;
  } if_id_entry_t;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} fill_state_e;
endpackage

// File: rtl/if_id_entry_ram.sv
// if_id_entry_ram: 2-entry register array (clk, we, wr_ptr, wdata in; rd_ptr in, async rdata out)
module if_id_entry_ram import core_pkg::*; (
  input  logic                clk,
  input  logic                we,
  input  logic                wr_ptr,
  input  logic [3*XLEN-1:0]   wdata,
  input  logic                rd_ptr,
  output logic [3*XLEN-1:0]   rdata
);
  logic [3*XLEN-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[wr_ptr] <= wdata;
  assign rdata = mem[rd_ptr];
endmodule

// File: rtl/if_id_buffer.sv
// if_id_buffer: 2-entry FWFT fetch->decode queue (in_* push side, out_* pop side, flush, occupancy)
module if_id_buffer import core_pkg::*; (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_pc_plus_four,
  input  logic [XLEN-1:0] in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus_four,
  output logic [XLEN-1:0] out_instr,
  output logic [1:0]      occupancy
);
  fill_state_e state, next;
  logic rd_ptr, wr_ptr, push, pop;
  if_id_entry_t head;
  assign in_ready = state != FULL;
  assign out_valid = state != EMPTY;
  assign occupancy = state;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  if_id_entry_ram u_ram (
    .clk    (clk),
    .we     (push & ~flush & ~rst),
    .wr_ptr (wr_ptr),
    .wdata  ({in_pc, in_pc_plus_four, in_instr}),
    .rd_ptr (rd_ptr),
    .rdata  (head)
  );
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= EMPTY;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      state <= next;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end
  always_comb begin
    next = state;
    if (push && !pop) next = (state == EMPTY) ? ONE : FULL;
    else if (pop && !push) next = (state == FULL) ? ONE : EMPTY;
    out_pc = out_valid ? head.pc : '0;
    out_pc_plus_four = out_valid ? head.pc_plus_four : '0;
    out_instr = out_valid ? head.instr : NOP_INSTR;
  end
endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: directed and random checks of if_id_buffer against a queue model
module tb_if_id_buffer;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } ent_t;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [31:0] in_pc = 0, in_pc_plus_four = 0, in_instr = 0;
  logic [31:0] out_pc, out_pc_plus_four, out_instr;
  logic [1:0] occupancy;
  ent_t q[$];
  bit checking = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  if_id_buffer dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_pc_plus_four(in_pc_plus_four), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_pc_plus_four(out_pc_plus_four), .out_instr(out_instr), .occupancy(occupancy)
  );
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", n, a, e, $time);
    end
  endtask
  always @(posedge clk) begin
    bit push, pop;
    push = in_valid && q.size() < 2;
    pop = out_ready && q.size() > 0;
    if (rst || flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{in_pc, in_pc_plus_four, in_instr});
    end
  end
  always @(negedge clk) if (checking) begin
    chk("m_occupancy", {30'd0, occupancy}, q.size());
    chk("m_out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    chk("m_in_ready", {31'd0, in_ready}, {31'd0, q.size() != 2});
    chk("m_out_pc", out_pc, q.size() != 0 ? q[0].pc : 32'h0);
    chk("m_out_pc4", out_pc_plus_four, q.size() != 0 ? q[0].pc4 : 32'h0);
    chk("m_out_instr", out_instr, q.size() != 0 ? q[0].instr : 32'h00000013);
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(logic v, logic [31:0] pc);
    in_valid = v;
    in_pc = pc;
    in_pc_plus_four = pc + 32'd4;
    in_instr = $urandom;
  endtask
  initial begin
    repeat (2) cyc();
    chk("rst_occ", {30'd0, occupancy}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_out_instr", out_instr, 32'h00000013);
    chk("rst_out_pc", out_pc, 0);
    rst = 0;
    checking = 1;
    drive(1, 32'h0);
    in_instr = 32'h00500093;
    out_ready = 1;
    cyc();
    in_valid = 0;
    chk("sp_valid", {31'd0, out_valid}, 1);
    chk("sp_pc", out_pc, 32'h0);
    chk("sp_pc4", out_pc_plus_four, 32'h4);
    chk("sp_instr", out_instr, 32'h00500093);
    cyc();
    chk("sp_drained", {31'd0, out_valid}, 0);
    out_ready = 0;
    drive(1, 32'h0);
    cyc();
    drive(1, 32'h4);
    cyc();
    chk("bp_in_ready", {31'd0, in_ready}, 0);
    chk("bp_occ", {30'd0, occupancy}, 2);
    drive(1, 32'h8);
    cyc();
    chk("bp_occ_hold", {30'd0, occupancy}, 2);
    in_valid = 0;
    out_ready = 1;
    chk("bp_head0", out_pc, 32'h0);
    cyc();
    chk("bp_in_ready_back", {31'd0, in_ready}, 1);
    chk("bp_head1", out_pc, 32'h4);
    cyc();
    chk("bp_empty", {31'd0, out_valid}, 0);
    out_ready = 0;
    drive(1, 32'h10);
    cyc();
    chk("st_occ1", {30'd0, occupancy}, 1);
    drive(1, 32'h14);
    out_ready = 1;
    cyc();
    chk("st_occ_keep", {30'd0, occupancy}, 1);
    chk("st_head", out_pc, 32'h14);
    for (int i = 0; i < 8; i++) begin
      drive(1, 32'h18 + 32'(4 * i));
      cyc();
      chk("st_stream_occ", {30'd0, occupancy}, 1);
      chk("st_stream_pc", out_pc, 32'h18 + 32'(4 * i));
    end
    in_valid = 0;
    cyc();
    chk("st_drain", {31'd0, out_valid}, 0);
    out_ready = 0;
    drive(1, 32'h100);
    cyc();
    drive(1, 32'h104);
    cyc();
    chk("fl_full", {30'd0, occupancy}, 2);
    flush = 1;
    drive(1, 32'h20);
    cyc();
    flush = 0;
    in_valid = 0;
    chk("fl_occ", {30'd0, occupancy}, 0);
    chk("fl_valid", {31'd0, out_valid}, 0);
    drive(1, 32'h40);
    cyc();
    in_valid = 0;
    chk("fl_next_pc", out_pc, 32'h40);
    rst = 1;
    flush = 1;
    cyc();
    rst = 0;
    flush = 0;
    chk("pr_occ", {30'd0, occupancy}, 0);
    chk("pr_valid", {31'd0, out_valid}, 0);
    chk("pr_instr", out_instr, 32'h00000013);
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 32'h1000 + 32'(4 * i));
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush = $urandom_range(0, 31) == 0;
      rst = $urandom_range(0, 255) == 0;
      cyc();
    end
    in_valid = 0;
    flush = 0;
    rst = 0;
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
